stack_game_ctrl: RTL and testbench

//  Game sequencer for the stacking display datapath. Owns the tower state and

---
 rtl/stack_game_ctrl_if.sv | 26 ++
 rtl/stack_game_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_stack_game_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/stack_game_ctrl_if.sv
// Control/status bundle between the stacking game sequencer and its user.
// slave = sequencer side, master = stimulus/consumer side.
interface stack_game_ctrl_if;
  logic        tick;
  logic        start;
  logic        drop;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic [31:0] colors;
  logic [9:0]  fall_x;
  logic [9:0]  fall_y;
  logic [1:0]  fall_clr;
  logic [4:0]  height;
  logic        game_over;
  logic        win;

  modport slave (
    input  tick, start, drop,
    output pos_x, pos_y, colors, fall_x, fall_y, fall_clr, height, game_over, win
  );

  modport master (
    output tick, start, drop,
    input  pos_x, pos_y, colors, fall_x, fall_y, fall_clr, height, game_over, win
  );
endinterface

// File: rtl/stack_game_ctrl.sv
// Stacking game sequencer: spawn, swing, drop, land, score the hit or end the game.
// Define LFSR_COLOR_EN to draw block colours from an 8-bit LFSR instead of R/G/B rotation.
module stack_game_ctrl #(
  parameter logic [9:0] STACK_X    = 10'd260,
  parameter logic [9:0] STACK_Y    = 10'd400,
  parameter logic [9:0] BLK_W      = 10'd100,
  parameter logic [9:0] BLK_H      = 10'd20,
  parameter logic [9:0] SPAWN_Y    = 10'd40,
  parameter logic [9:0] X_MIN      = 10'd0,
  parameter logic [9:0] X_MAX      = 10'd540,
  parameter logic [9:0] SWING_STEP = 10'd4,
  parameter logic [9:0] FALL_STEP  = 10'd4,
  parameter logic [9:0] MIN_OVL    = 10'd20
) (
  input logic              clk,
  input logic              rst_n,
  stack_game_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWING = 3'd1;
  localparam logic [2:0] S_DROP  = 3'd2;
  localparam logic [2:0] S_LAND  = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;
  localparam logic [2:0] S_WIN   = 3'd5;

  localparam logic [1:0] CLR_NONE = 2'b00;
  localparam logic [1:0] CLR_G    = 2'b01;
  localparam logic [1:0] CLR_B    = 2'b10;
  localparam logic [1:0] CLR_R    = 2'b11;

  logic [2:0]  r_state;
  logic [31:0] r_colors;
  logic [1:0]  r_fall_clr;
  logic [9:0]  r_fall_x;
  logic [9:0]  r_fall_y;
  logic [4:0]  r_height;
  logic        r_dir_right;
  logic        r_game_over;
  logic        r_win;

  logic [9:0]  w_land_y;
  logic [10:0] w_dx;
  logic [10:0] w_x_inc;
  logic [10:0] w_x_left_lim;
  logic [10:0] w_y_inc;
  logic        w_hit;
  logic        w_last;
  logic        w_restart;
  logic        w_spawn;
  logic [1:0]  w_spawn_clr;

  assign w_land_y     = STACK_Y - ({5'd0, r_height} * BLK_H);
  assign w_dx         = (r_fall_x >= STACK_X) ? {1'b0, r_fall_x - STACK_X}
                                              : {1'b0, STACK_X - r_fall_x};
  assign w_hit        = w_dx <= {1'b0, BLK_W - MIN_OVL};
  assign w_last       = r_height == 5'd15;
  assign w_x_inc      = {1'b0, r_fall_x} + {1'b0, SWING_STEP};
  assign w_x_left_lim = {1'b0, X_MIN} + {1'b0, SWING_STEP};
  assign w_y_inc      = {1'b0, r_fall_y} + {1'b0, FALL_STEP};

  // A restart spawns from any idle-like state; a continuing hit spawns from LAND.
  assign w_restart = bus.start &&
                     ((r_state == S_IDLE) || (r_state == S_OVER) || (r_state == S_WIN));
  assign w_spawn   = w_restart || ((r_state == S_LAND) && w_hit && !w_last);

`ifdef LFSR_COLOR_EN
  logic [7:0] r_lfsr;

  // x^8+x^6+x^5+x^4+1, free-running, never reseeded by start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  assign w_spawn_clr = (r_lfsr[1:0] == CLR_NONE) ? CLR_R : r_lfsr[1:0];
`else
  logic [1:0] r_next_clr;

  assign w_spawn_clr = w_restart ? CLR_R : r_next_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_clr <= CLR_R;
    end else if (w_spawn) begin
      case (w_spawn_clr)
        CLR_R:   r_next_clr <= CLR_G;
        CLR_G:   r_next_clr <= CLR_B;
        default: r_next_clr <= CLR_R;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_colors    <= '0;
      r_fall_clr  <= CLR_NONE;
      r_fall_x    <= X_MIN;
      r_fall_y    <= SPAWN_Y;
      r_height    <= '0;
      r_dir_right <= 1'b1;
      r_game_over <= 1'b0;
      r_win       <= 1'b0;
    end else begin
      if (w_spawn) begin
        r_fall_clr  <= w_spawn_clr;
        r_fall_x    <= X_MIN;
        r_fall_y    <= SPAWN_Y;
        r_dir_right <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_SWING;
        end
        S_SWING: begin
          if (bus.drop) begin
            r_state <= S_DROP;
          end else if (bus.tick) begin
            if (r_dir_right) begin
              if (w_x_inc >= {1'b0, X_MAX}) begin
                r_fall_x    <= X_MAX;
                r_dir_right <= 1'b0;
              end else begin
                r_fall_x <= w_x_inc[9:0];
              end
            end else if ({1'b0, r_fall_x} <= w_x_left_lim) begin
              r_fall_x    <= X_MIN;
              r_dir_right <= 1'b1;
            end else begin
              r_fall_x <= r_fall_x - SWING_STEP;
            end
          end
        end
        S_DROP: begin
          if (bus.tick) begin
            if (w_y_inc >= {1'b0, w_land_y}) begin
              r_fall_y <= w_land_y;
              r_state  <= S_LAND;
            end else begin
              r_fall_y <= w_y_inc[9:0];
            end
          end
        end
        S_LAND: begin
          if (w_hit) begin
            r_colors[{r_height[3:0], 1'b0} +: 2] <= r_fall_clr;
            r_height                              <= r_height + 5'd1;
            if (w_last) begin
              r_state    <= S_WIN;
              r_win      <= 1'b1;
              r_fall_clr <= CLR_NONE;
            end else begin
              r_state <= S_SWING;
            end
          end else begin
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end
        end
        S_OVER, S_WIN: begin
          if (bus.start) begin
            r_colors    <= '0;
            r_height    <= '0;
            r_game_over <= 1'b0;
            r_win       <= 1'b0;
            r_state     <= S_SWING;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pos_x     = STACK_X;
  assign bus.pos_y     = STACK_Y;
  assign bus.colors    = r_colors;
  assign bus.fall_x    = r_fall_x;
  assign bus.fall_y    = r_fall_y;
  assign bus.fall_clr  = r_fall_clr;
  assign bus.height    = r_height;
  assign bus.game_over = r_game_over;
  assign bus.win       = r_win;

endmodule

// File: tb/tb_stack_game_ctrl.sv
// Bench for stack_game_ctrl (default colour rotation): landing outcomes are predicted
// into a scoreboard when a drop is issued and compared once the block has landed.
module tb_stack_game_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  stack_game_ctrl_if u_bus ();

  stack_game_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  height;
    logic [31:0] colors;
    logic [1:0]  clr;
    logic [9:0]  fall_y;
    logic        go;
    logic        win;
  } exp_t;

  exp_t        sb[$];
  int          m_h;
  logic [31:0] m_colors;
  logic [1:0]  m_clr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] next_clr(input logic [1:0] c);
    if (c == 2'b11) return 2'b01;
    if (c == 2'b01) return 2'b10;
    return 2'b11;
  endfunction

  task automatic pulse(input logic t, input logic s, input logic d);
    @(negedge clk);
    u_bus.tick  = t;
    u_bus.start = s;
    u_bus.drop  = d;
    @(negedge clk);
    u_bus.tick  = 1'b0;
    u_bus.start = 1'b0;
    u_bus.drop  = 1'b0;
  endtask

  task automatic start_game();
    pulse(1'b0, 1'b1, 1'b0);
    m_h      = 0;
    m_colors = '0;
    m_clr    = 2'b11;
  endtask

  // Drop from x (block assumed swinging there), predict outcome, tick until it lands.
  task automatic drop_here(input int x);
    exp_t e;
    int   dx;
    int   prev_h;
    bit   done;
    prev_h = int'(u_bus.height);
    pulse(1'b0, 1'b0, 1'b1);
    dx = (x > 260) ? x - 260 : 260 - x;
    e.go  = 1'b0;
    e.win = 1'b0;
    if (dx <= 80) begin
      m_colors[2*m_h +: 2] = m_clr;
      m_h++;
      if (m_h == 16) begin
        e.win    = 1'b1;
        m_clr    = 2'b00;
        e.fall_y = 10'(400 - 15 * 20);
      end else begin
        m_clr    = next_clr(m_clr);
        e.fall_y = 10'd40;
      end
    end else begin
      e.go     = 1'b1;
      e.fall_y = 10'(400 - m_h * 20);
    end
    e.height = 5'(m_h);
    e.colors = m_colors;
    e.clr    = m_clr;
    sb.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      if (int'(u_bus.height) != prev_h || u_bus.game_over || u_bus.win) done = 1'b1;
    end
    if (!done) check_eq("land_timeout", 32'd0, 32'd1);
    e = sb.pop_front();
    check_eq("land_height", 32'(u_bus.height), 32'(e.height));
    check_eq("land_colors", u_bus.colors, e.colors);
    check_eq("land_clr", 32'(u_bus.fall_clr), 32'(e.clr));
    check_eq("land_fall_y", 32'(u_bus.fall_y), 32'(e.fall_y));
    check_eq("land_over", 32'(u_bus.game_over), 32'(e.go));
    check_eq("land_win", 32'(u_bus.win), 32'(e.win));
  endtask

  task automatic drop_at(input int n_ticks);
    repeat (n_ticks) pulse(1'b1, 1'b0, 1'b0);
    drop_here(n_ticks * 4);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pos_x"}, 32'(u_bus.pos_x), 32'd260);
    check_eq({tag, "_pos_y"}, 32'(u_bus.pos_y), 32'd400);
    check_eq({tag, "_colors"}, u_bus.colors, 32'd0);
    check_eq({tag, "_clr"}, 32'(u_bus.fall_clr), 32'd0);
    check_eq({tag, "_fx"}, 32'(u_bus.fall_x), 32'd0);
    check_eq({tag, "_fy"}, 32'(u_bus.fall_y), 32'd40);
    check_eq({tag, "_height"}, 32'(u_bus.height), 32'd0);
    check_eq({tag, "_over"}, 32'(u_bus.game_over), 32'd0);
    check_eq({tag, "_win"}, 32'(u_bus.win), 32'd0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    u_bus.tick  = 1'b0;
    u_bus.start = 1'b0;
    u_bus.drop  = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // Abort mid-drop: outputs must snap back before any clock edge.
    start_game();
    repeat (5) pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (5) pulse(1'b1, 1'b0, 1'b0);
    check_eq("pre_abort_fy", 32'(u_bus.fall_y), 32'd60);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;

    start_game();
    check_eq("spawn_clr", 32'(u_bus.fall_clr), 32'd3);
    check_eq("spawn_fx", 32'(u_bus.fall_x), 32'd0);
    check_eq("spawn_fy", 32'(u_bus.fall_y), 32'd40);

    // Swing to the right limit and back.
    repeat (135) pulse(1'b1, 1'b0, 1'b0);
    check_eq("swing_max", 32'(u_bus.fall_x), 32'd540);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("swing_back", 32'(u_bus.fall_x), 32'd536);
    drop_here(536);
    check_eq("miss_fx", 32'(u_bus.fall_x), 32'd536);

    // Aligned hit, overlap boundary hit, just-past-boundary miss.
    start_game();
    drop_at(65);
    check_eq("next_fx", 32'(u_bus.fall_x), 32'd0);
    drop_at(85);
    drop_at(86);
    pulse(1'b0, 1'b0, 1'b1);
    check_eq("over_drop_ign", 32'(u_bus.game_over), 32'd1);

    // Full tower.
    start_game();
    check_eq("restart_colors", u_bus.colors, 32'd0);
    check_eq("restart_height", 32'(u_bus.height), 32'd0);
    check_eq("restart_over", 32'(u_bus.game_over), 32'd0);
    for (int i = 0; i < 16; i++) drop_at(65);
    check_eq("win_colors", u_bus.colors, 32'hE79E79E7);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("win_hold", 32'(u_bus.win), 32'd1);
    start_game();
    check_eq("win_restart_colors", u_bus.colors, 32'd0);
    check_eq("win_restart_win", 32'(u_bus.win), 32'd0);
    check_eq("win_restart_clr", 32'(u_bus.fall_clr), 32'd3);

    // drop and tick together: drop wins, x holds; start ignored while dropping.
    repeat (10) pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1);
    check_eq("dt_fx", 32'(u_bus.fall_x), 32'd40);
    check_eq("dt_fy", 32'(u_bus.fall_y), 32'd40);
    pulse(1'b1, 1'b0, 1'b0);
    check_eq("dt_fall_fy", 32'(u_bus.fall_y), 32'd44);
    check_eq("dt_fall_fx", 32'(u_bus.fall_x), 32'd40);
    pulse(1'b0, 1'b1, 1'b0);
    check_eq("drop_start_ign", 32'(u_bus.fall_y), 32'd44);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
